// File: rtl/scsa_vl_ctrl.sv
// Variable-latency controller around a windowed speculative-carry adder.
// Two cycles accept-to-valid when speculation holds (or approx mode), three with correction.
module scsa_vl_ctrl #(
  parameter int W     = 16,
  parameter int WIN   = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic             cin,
  input  logic             approx_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     sum,
  output logic             cout,
  output logic             out_err,
  output logic             out_corr,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] op_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {IDLE, EVAL, CORR, OUT} state_t;

  state_t             state_q, state_d;
  logic [W-1:0]       a_q, b_q;
  logic               cin_q, apx_q;
  logic [W-1:0]       sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               err_q, err_d;
  logic               corr_q, corr_d;
  logic [CNT_W-1:0]   op_cnt_q, op_cnt_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;

  logic [W-1:0]       p, g;
  logic [W:0]         c, cs;
  logic               win_c;
  logic               spec_err;
  logic               accept, op_inc, err_inc;

  // Exact ripple carries plus, for each position at or above the window, the carry
  // generated inside the WIN bits just below it assuming a zero carry into the window.
  always_comb begin
    p     = a_q ^ b_q;
    g     = a_q & b_q;
    c     = '0;
    c[0]  = cin_q;
    win_c = 1'b0;
    for (int i = 0; i < W; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    cs = c;
    if (WIN < W) begin
      for (int i = WIN; i <= W; i++) begin
        win_c = 1'b0;
        for (int k = i - WIN; k < i; k++) begin
          win_c = g[k] | (p[k] & win_c);
        end
        cs[i] = win_c;
      end
    end
    spec_err = (cs != c);
  end

  assign accept  = (state_q == IDLE) && in_valid;
  assign op_inc  = (state_q == OUT) && out_ready;
  assign err_inc = (state_q == EVAL) && spec_err;

  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    err_d   = err_q;
    corr_d  = corr_q;
    unique case (state_q)
      IDLE: if (in_valid) state_d = EVAL;
      EVAL: begin
        if (spec_err && !apx_q) begin
          state_d = CORR;
        end else begin
          sum_d   = p ^ cs[W-1:0];
          cout_d  = cs[W];
          err_d   = spec_err;
          corr_d  = 1'b0;
          state_d = OUT;
        end
      end
      CORR: begin
        sum_d   = p ^ c[W-1:0];
        cout_d  = c[W];
        err_d   = 1'b1;
        corr_d  = 1'b1;
        state_d = OUT;
      end
      OUT: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Clear has priority over a same-cycle increment; increments stick at all-ones.
  always_comb begin
    op_cnt_d  = op_cnt_q;
    err_cnt_d = err_cnt_q;
    if (clr_cnt) begin
      op_cnt_d  = '0;
      err_cnt_d = '0;
    end else begin
      if (op_inc && (op_cnt_q != '1))   op_cnt_d  = op_cnt_q + 1'b1;
      if (err_inc && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      cin_q     <= 1'b0;
      apx_q     <= 1'b0;
      sum_q     <= '0;
      cout_q    <= 1'b0;
      err_q     <= 1'b0;
      corr_q    <= 1'b0;
      op_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      sum_q     <= sum_d;
      cout_q    <= cout_d;
      err_q     <= err_d;
      corr_q    <= corr_d;
      op_cnt_q  <= op_cnt_d;
      err_cnt_q <= err_cnt_d;
      if (accept) begin
        a_q   <= a;
        b_q   <= b;
        cin_q <= cin;
        apx_q <= approx_en;
      end
    end
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == OUT);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign out_err   = err_q;
  assign out_corr  = corr_q;
  assign op_cnt    = op_cnt_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_scsa_vl_ctrl.sv
// Directed plus randomized bench for scsa_vl_ctrl; reference model uses plain integer
// addition over carry windows. Counters are narrowed so saturation is reachable quickly.
module tb_scsa_vl_ctrl;
  localparam int W     = 16;
  localparam int WIN   = 8;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [W-1:0]     a = '0, b = '0;
  logic             cin = 1'b0, approx_en = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [W-1:0]     sum;
  logic             cout, out_err, out_corr;
  logic             clr_cnt = 1'b0;
  logic [CNT_W-1:0] op_cnt, err_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int op_m  = 0;
  int err_m = 0;

  scsa_vl_ctrl #(.W(W), .WIN(WIN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .approx_en(approx_en),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout),
    .out_err(out_err), .out_corr(out_corr), .clr_cnt(clr_cnt),
    .op_cnt(op_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  // Carry into bit i is bit i of the sum of the operands' low i bits; the speculative
  // carry is bit WIN of the sum of the WIN-bit operand slices just below i.
  function automatic void ref_model(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                    input logic rci, input logic rapx,
                                    output logic [W-1:0] rs, output logic rco,
                                    output logic rer, output logic rcr, output int rlat);
    longint unsigned ua, ub, mask, wmask, exact, lo;
    logic [W:0] cv, csv;
    ua    = longint'(ra);
    ub    = longint'(rb);
    wmask = (64'd1 << WIN) - 64'd1;
    exact = ua + ub + longint'(rci);
    for (int i = 0; i <= W; i++) begin
      mask  = (64'd1 << i) - 64'd1;
      lo    = (ua & mask) + (ub & mask) + longint'(rci);
      cv[i] = ((lo >> i) & 64'd1) != 0;
      if (i < WIN) csv[i] = cv[i];
      else csv[i] = ((((ua >> (i - WIN)) & wmask) + ((ub >> (i - WIN)) & wmask)) >> WIN) != 0;
    end
    rer = (cv != csv);
    if (rer && !rapx) begin
      rs = exact[W-1:0]; rco = exact[W]; rcr = 1'b1; rlat = 3;
    end else begin
      rs = ra ^ rb ^ csv[W-1:0]; rco = csv[W]; rcr = 1'b0; rlat = 2;
    end
  endfunction

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tci,
                        input logic tapx, input int hold, input bit early, input bit clr_hs);
    logic [W-1:0] es;
    logic ec, ee, ecr;
    int el, lat;
    bit got;
    ref_model(ta, tb_v, tci, tapx, es, ec, ee, ecr, el);
    for (int k = 0; k < 20 && !in_ready; k++) @(negedge clk);
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    a = ta; b = tb_v; cin = tci; approx_en = tapx; in_valid = 1'b1;
    out_ready = early;
    lat = 0; got = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); lat++;
      @(negedge clk);
      in_valid = 1'b0;
      a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); approx_en = 1'($urandom);
      if (lat == 1) chk("in_ready_busy", 32'(in_ready), 32'd0);
      if (out_valid) begin got = 1; break; end
    end
    chk("out_valid_seen", 32'(got), 32'd1);
    if (!got) return;
    err_m = sat(err_m + int'(ee));
    chk("latency", 32'(lat), 32'(el));
    chk("sum", 32'(sum), 32'(es));
    chk("cout", 32'(cout), 32'(ec));
    chk("out_err", 32'(out_err), 32'(ee));
    chk("out_corr", 32'(out_corr), 32'(ecr));
    chk("err_cnt", 32'(err_cnt), 32'(err_m));
    if (!early) begin
      for (int k = 0; k < hold; k++) begin
        @(posedge clk); @(negedge clk);
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_sum", 32'(sum), 32'(es));
        chk("hold_flags", {29'd0, cout, out_err, out_corr}, {29'd0, ec, ee, ecr});
        chk("hold_in_ready", 32'(in_ready), 32'd0);
        chk("hold_op_cnt", 32'(op_cnt), 32'(op_m));
      end
    end
    out_ready = 1'b1; clr_cnt = clr_hs;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0; clr_cnt = 1'b0;
    if (clr_hs) begin op_m = 0; err_m = 0; end
    else op_m = sat(op_m + 1);
    chk("post_valid", 32'(out_valid), 32'd0);
    chk("post_in_ready", 32'(in_ready), 32'd1);
    chk("op_cnt", 32'(op_cnt), 32'(op_m));
    chk("post_err_cnt", 32'(err_cnt), 32'(err_m));
    chk("post_sum_held", 32'(sum), 32'(es));
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    #2;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_outs", {15'd0, sum, cout, out_err, out_corr}, 32'd0);
    chk("rst_cnts", {24'd0, op_cnt, err_cnt}, 32'd0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);

    run_op(16'h0001, 16'h0002, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b1, 0, 1'b1, 1'b0);
    run_op(16'h00FF, 16'hFF00, 1'b1, 1'b0, 1, 1'b0, 1'b0);
    run_op(16'h00FF, 16'hFF00, 1'b1, 1'b1, 0, 1'b1, 1'b0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 5, 1'b0, 1'b0);
    run_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 5, 1'b0, 1'b0);

    for (int n = 0; n < 30; n++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if ($urandom_range(0, 1) == 1) rb = ~ra ^ (16'(1) << $urandom_range(0, 15));
      run_op(ra, rb, 1'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
             bit'($urandom_range(0, 1)), 1'b0);
    end

    // Reset while in the correction cycle discards the operation.
    a = 16'h7FFF; b = 16'h0001; cin = 1'b0; approx_en = 1'b0; in_valid = 1'b1;
    @(posedge clk); @(negedge clk); in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    #1;
    chk("corr_rst_in_ready", 32'(in_ready), 32'd0);
    chk("corr_rst_valid", 32'(out_valid), 32'd0);
    chk("corr_rst_outs", {15'd0, sum, cout, out_err, out_corr}, 32'd0);
    chk("corr_rst_cnts", {24'd0, op_cnt, err_cnt}, 32'd0);
    op_m = 0; err_m = 0;
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("no_result_after_rst", 32'(out_valid), 32'd0);
    end

    for (int n = 0; n < CMAX + 2; n++) run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, 1'b1, 1'b0);
    chk("op_cnt_sat", 32'(op_cnt), 32'(CMAX));
    chk("err_cnt_sat", 32'(err_cnt), 32'(CMAX));
    run_op(16'h1234, 16'h0101, 1'b0, 1'b0, 2, 1'b0, 1'b1);
    run_op(16'h0001, 16'h0002, 1'b0, 1'b0, 0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/scsa_vl_ctrl.md
Name: scsa_vl_ctrl

Overview:
Variable-latency controller for the 16-bit speculative carry-select/Han-Carlson adder datapath. It accepts one operand pair per transaction and evaluates the speculative (windowed-carry) sum. It detects a speculation error and either corrects it with one extra cycle or, in approximate mode, forwards the speculative result flagged as erroneous. It sits between an operand producer and a result consumer, with valid/ready handshakes on both sides and saturating statistics counters.

Parameters:
W, 16, operand and sum width
WIN, 8, speculation window; for bit i >= WIN, the speculative carry into bit i uses only bits [i-WIN .. i-1] with carry-in 0 (1 <= WIN <= W)
CNT_W, 16, width of op_cnt / err_cnt

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
in_valid  input  1  operand pair valid
in_ready  output  1  controller can accept operands
a  input  W  operand A
b  input  W  operand B
cin  input  1  carry in
approx_en  input  1  1 = never correct; sampled with operands
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
sum  output  W  result sum
cout  output  1  result carry out
out_err  output  1  speculation error was detected for this result
out_corr  output  1  result was corrected (exact)
clr_cnt  input  1  synchronous clear of both counters
op_cnt  output  CNT_W  completed output handshakes, saturating
err_cnt  output  CNT_W  detected speculation errors, saturating

Behaviour:
- Reset (async, any state): state=IDLE. in_ready=0 while rst is high. out_valid, sum, cout, out_err, out_corr, op_cnt and err_cnt all go to 0. Any in-flight operation is discarded, with no output.
- Arithmetic: p=a^b, g=a&b. The exact carry c[0]=cin, c[i+1]=g[i]|(p[i]&c[i]).
- Speculative carry cs[i]=c[i] for i<WIN. For WIN<=i<=W, cs[i] is the carry out of bits [i-WIN..i-1] with carry-in 0. Speculative cout=cs[W].
- Error: err=1 iff there is any i in [WIN..W] with c[i]!=cs[i]. Equivalently, c[i-WIN]=1 and p[i-WIN..i-1] all 1.
- FSM states: IDLE, EVAL, CORR, OUT.
  - IDLE: in_ready=1. On in_valid, register a, b, cin and approx_en, then go to EVAL.
  - EVAL (1 cycle): compute the speculative sum (s[i]=p[i]^cs[i]) and err. If err, increment err_cnt.
    - If !err or approx: load sum/cout with the speculative values, out_err=err, out_corr=0, go to OUT.
    - Otherwise go to CORR.
  - CORR (1 cycle): load sum/cout with the exact values, out_err=1, out_corr=1, go to OUT.
  - OUT: out_valid=1. sum, cout, out_err and out_corr are held stable. When out_ready=1: increment op_cnt, go to IDLE.
- Latency: accept edge to out_valid=1 is 2 cycles without correction, 3 cycles with correction.
- Throughput: in_ready is 0 in EVAL, CORR and OUT. There is no back-to-back acceptance, so each transaction takes at least 3 cycles.
- out_valid drops the cycle after the output handshake. sum, cout, out_err and out_corr keep their last values when out_valid=0.
- Inputs a, b, cin and approx_en are ignored outside an IDLE accept.
- Counters saturate at all-ones. clr_cnt=1 zeroes both counters and wins over a same-cycle increment.
- WIN>=W degenerates to an exact adder: err is always 0 and latency is always 2.
- out_ready held high while in EVAL or CORR has no effect.

Test Plan:
1. W=16, WIN=8, a=0x0001, b=0x0002, cin=0, approx_en=0 -> out_valid 2 cycles after accept; sum=0x0003, cout=0, out_err=0, out_corr=0; op_cnt=1, err_cnt=0.
2. a=0x7FFF, b=0x0001, cin=0, approx_en=0 -> out_valid 3 cycles after accept; sum=0x8000, cout=0, out_err=1, out_corr=1; err_cnt increments.
3. Same operands as scenario 2 with approx_en=1 -> 2-cycle latency; sum=0x7E00, cout=0, out_err=1, out_corr=0.
4. a=0x00FF, b=0xFF00, cin=1, approx_en=0 -> sum=0x0000, cout=1, out_corr=1. Repeat with approx_en=1 -> sum=0xFF00, cout=0, out_err=1.
5. Backpressure: hold out_ready=0 for 5 cycles in OUT -> out_valid, sum and flags stay stable, in_ready=0, op_cnt unchanged; then raise out_ready -> op_cnt+1 and IDLE next cycle. Assert rst in CORR -> all outputs 0 immediately and no result is produced.
6. Preload counters to 0xFFFF via repeated ops (or force) -> no wrap. clr_cnt asserted in the same cycle as an op_cnt increment -> op_cnt=0.
